multisim_push_arbiter: RTL and testbench

- Shares one multisim push channel (the client push module's data_vld/data/data_rdy handshake) among NUM_REQ local requesters.
- Round-robin arbitration with one output holding register.
- Each beat is tagged with the index of its source requester, so the server side can demultiplex.
- Sits between several DUT-side producers and a single push client instance.

---
 rtl/multisim_arb_pkg.sv | 37 +++
 rtl/multisim_push_arbiter_if.sv | 30 +++
 rtl/multisim_rr_grant.sv | 30 +++
 rtl/multisim_push_arbiter.sv | 103 ++++++++++
 tb/tb_multisim_push_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/multisim_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the multisim
// push/pull arbiters.
package multisim_arb_pkg;

   localparam int BUSY_CNT_W = 16;
   localparam int MAX_REQ    = 16;
   localparam int PTR_W      = 4;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // One-hot pick of the first eligible index at or after ptr, wrapping at num_req.
   // Vectors are sized for the largest supported arbiter; callers zero-extend.
   function automatic logic [MAX_REQ-1:0] rr_pick(
      input logic [MAX_REQ-1:0] elig,
      input logic [PTR_W-1:0]   ptr,
      input int                 num_req
   );
      logic [MAX_REQ-1:0] gnt;
      logic               found;
      int                 idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= num_req) idx = idx - num_req;
         if ((k < num_req) && !found && elig[idx[PTR_W-1:0]]) begin
            gnt[idx[PTR_W-1:0]] = 1'b1;
            found               = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/multisim_push_arbiter_if.sv
// Requester-side and push-client-side signals of the multisim push arbiter.
interface multisim_push_arbiter_if
   import multisim_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64
);
   localparam int IDX_W     = $clog2(NUM_REQ);
   localparam int OUT_WIDTH = DATA_WIDTH + IDX_W;

   logic [NUM_REQ-1:0]            req_vld;
   logic [NUM_REQ-1:0]            req_rdy;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_mask;
   logic                          out_vld;
   logic                          out_rdy;
   logic [OUT_WIDTH-1:0]          out_data;
   logic [BUSY_CNT_W-1:0]         busy_cnt;

   modport master (
      output req_vld, req_data, req_mask, out_rdy,
      input  req_rdy, out_vld, out_data, busy_cnt
   );

   modport slave (
      input  req_vld, req_data, req_mask, out_rdy,
      output req_rdy, out_vld, out_data, busy_cnt
   );

endinterface

// File: rtl/multisim_rr_grant.sv
// Combinational round-robin picker: one-hot grant plus its encoded index.
module multisim_rr_grant
   import multisim_arb_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] elig,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   logic [MAX_REQ-1:0] pick;

   always_comb begin
      pick    = rr_pick(MAX_REQ'(elig), PTR_W'(ptr), NUM_REQ);
      gnt     = pick[NUM_REQ-1:0];
      gnt_any = |pick;
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) gnt_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/multisim_push_arbiter.sv
// Round-robin arbiter sharing one multisim push channel among NUM_REQ requesters;
// each beat leaves through a single holding register tagged with its source index.
module multisim_push_arbiter
   import multisim_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64
) (
   input logic                    clk,
   input logic                    rst,
   multisim_push_arbiter_if.slave bus
);

   localparam int IDX_W     = $clog2(NUM_REQ);
   localparam int OUT_WIDTH = DATA_WIDTH + IDX_W;

   logic [DATA_WIDTH-1:0] req_payload [NUM_REQ];
   logic [NUM_REQ-1:0]    elig;
   logic [NUM_REQ-1:0]    gnt;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  gnt_any;
   logic                  load;
   logic                  xfer;
   logic                  stall;

   out_state_t            state_reg;
   out_state_t            state_next;
   logic [OUT_WIDTH-1:0]  out_data_reg;
   logic [IDX_W-1:0]      rr_ptr_reg;
   logic [BUSY_CNT_W-1:0] busy_cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_payload[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   always_comb elig = bus.req_vld & bus.req_mask;

   multisim_rr_grant #(
      .NUM_REQ (NUM_REQ)
   ) u_grant (
      .elig    (elig),
      .ptr     (rr_ptr_reg),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // The holding register can accept a beat when empty or when draining this cycle.
   always_comb begin
      load        = (state_reg == OUT_EMPTY) || bus.out_rdy;
      bus.req_rdy = gnt & {NUM_REQ{load & !rst}};
      xfer        = gnt_any & load & !rst;
      stall       = (state_reg == OUT_FULL) && !bus.out_rdy;
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= OUT_EMPTY;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         OUT_EMPTY: if (xfer) state_next = OUT_FULL;
         OUT_FULL:  if (bus.out_rdy && !xfer) state_next = OUT_EMPTY;
         default:   state_next = OUT_EMPTY;
      endcase
   end

   always_comb begin
      bus.out_vld  = (state_reg == OUT_FULL);
      bus.out_data = out_data_reg;
      bus.busy_cnt = busy_cnt_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_reg <= '0;
         rr_ptr_reg   <= '0;
         busy_cnt_reg <= '0;
      end else begin
         if (xfer) begin
            out_data_reg <= {gnt_idx, req_payload[gnt_idx]};
            rr_ptr_reg   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
         end
         if (stall && (busy_cnt_reg != {BUSY_CNT_W{1'b1}}))
            busy_cnt_reg <= busy_cnt_reg + BUSY_CNT_W'(1);
      end
   end

   // A requester left waiting must hold its request and payload steady.
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_proto
         assert property (@(posedge clk) disable iff (rst)
            (bus.req_vld[gi] && !bus.req_rdy[gi]) |=>
            (bus.req_vld[gi] && $stable(bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH])));
      end
   endgenerate

endmodule

// File: tb/tb_multisim_push_arbiter.sv
// Directed bench for multisim_push_arbiter: reset, round-robin, backpressure,
// masking, pointer wrap and reset during a stall.
module tb_multisim_push_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   multisim_push_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

   multisim_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "timeout");
   end

   function automatic logic [DW-1:0] payload(input int i);
      return 64'h0123_4567_89AB_C000 + 64'(i);
   endfunction

   function automatic logic [DW+1:0] beat(input int t, input logic [DW-1:0] d);
      return {2'(t), d};
   endfunction

   task automatic load_payloads();
      for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = payload(i);
   endtask

   // Drops every request together with rst so no waiting requester is seen to withdraw.
   task automatic reset_dut();
      @(negedge clk);
      rst          = 1'b1;
      bus.req_vld  = '0;
      bus.req_mask = '1;
      bus.out_rdy  = 1'b0;
      load_payloads();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.req_vld  = 4'b1111;
      bus.req_mask = 4'b1111;
      bus.out_rdy  = 1'b1;
      load_payloads();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.req_rdy !== 4'b0000) begin n_bad++; $display("FAIL reset_req_rdy got %b want 0000", bus.req_rdy); end
         n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL reset_out_vld got %b want 0", bus.out_vld); end
         n_cmp++; if (bus.out_data !== 66'd0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
         n_cmp++; if (bus.busy_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_busy_cnt got %0d want 0", bus.busy_cnt); end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt got %b want 0001", bus.req_rdy); end
      @(negedge clk); #1;
      n_cmp++; if (bus.out_vld !== 1'b1) begin n_bad++; $display("FAIL reset_first_vld got %b want 1", bus.out_vld); end
      n_cmp++; if (bus.out_data !== beat(0, payload(0))) begin n_bad++; $display("FAIL reset_first_beat got %h want %h", bus.out_data, beat(0, payload(0))); end
      $display("reset: first beat tag=%0d", bus.out_data[DW +: 2]);
   endtask

   task automatic test_round_robin();
      reset_dut();
      @(negedge clk);
      rst         = 1'b0;
      bus.req_vld = 4'b1111;
      bus.out_rdy = 1'b1;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0001) begin n_bad++; $display("FAIL rr_first_gnt got %b want 0001", bus.req_rdy); end
      n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL rr_latency got %b want 0", bus.out_vld); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.out_vld !== 1'b1) begin n_bad++; $display("FAIL rr_vld k=%0d got %b want 1", k, bus.out_vld); end
         n_cmp++; if (bus.out_data !== beat(k % 4, payload(k % 4))) begin n_bad++; $display("FAIL rr_beat k=%0d got %h want %h", k, bus.out_data, beat(k % 4, payload(k % 4))); end
         n_cmp++; if (bus.req_rdy !== 4'(1 << ((k + 1) % 4))) begin n_bad++; $display("FAIL rr_gnt k=%0d got %b want %b", k, bus.req_rdy, 4'(1 << ((k + 1) % 4))); end
         $display("rr: beat %0d tag=%0d", k, bus.out_data[DW +: 2]);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] dead;
      dead = 64'h0000_0000_DEAD_BEEF;
      reset_dut();
      bus.req_data[2*DW +: DW] = dead;
      @(negedge clk);
      rst         = 1'b0;
      bus.req_vld = 4'b1100;
      bus.out_rdy = 1'b0;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0100) begin n_bad++; $display("FAIL bp_first_gnt got %b want 0100", bus.req_rdy); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.out_vld !== 1'b1) begin n_bad++; $display("FAIL bp_vld i=%0d got %b want 1", i, bus.out_vld); end
         n_cmp++; if (bus.out_data !== beat(2, dead)) begin n_bad++; $display("FAIL bp_hold i=%0d got %h want %h", i, bus.out_data, beat(2, dead)); end
         n_cmp++; if (bus.req_rdy !== 4'b0000) begin n_bad++; $display("FAIL bp_rdy i=%0d got %b want 0000", i, bus.req_rdy); end
         n_cmp++; if (bus.busy_cnt !== 16'(i)) begin n_bad++; $display("FAIL bp_busy i=%0d got %0d want %0d", i, bus.busy_cnt, i); end
         $display("bp: stall cycle %0d busy_cnt=%0d", i, bus.busy_cnt);
      end
      @(negedge clk); #1;
      n_cmp++; if (bus.busy_cnt !== 16'd5) begin n_bad++; $display("FAIL bp_busy_final got %0d want 5", bus.busy_cnt); end
      n_cmp++; if (bus.out_data !== beat(2, dead)) begin n_bad++; $display("FAIL bp_hold_final got %h want %h", bus.out_data, beat(2, dead)); end
      bus.out_rdy = 1'b1;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b1000) begin n_bad++; $display("FAIL bp_release_gnt got %b want 1000", bus.req_rdy); end
      @(negedge clk); #1;
      n_cmp++; if (bus.out_data !== beat(3, payload(3))) begin n_bad++; $display("FAIL bp_next_beat got %h want %h", bus.out_data, beat(3, payload(3))); end
      n_cmp++; if (bus.busy_cnt !== 16'd5) begin n_bad++; $display("FAIL bp_busy_after got %0d want 5", bus.busy_cnt); end
      n_cmp++; if (bus.req_rdy !== 4'b0100) begin n_bad++; $display("FAIL bp_wrap_gnt got %b want 0100", bus.req_rdy); end
      $display("bp: drained, next tag=%0d", bus.out_data[DW +: 2]);
   endtask

   task automatic test_mask();
      int tags [3];
      logic [3:0] rdys [3];
      tags = '{1, 3, 1};
      rdys = '{4'b1000, 4'b0010, 4'b1000};
      reset_dut();
      @(negedge clk);
      rst          = 1'b0;
      bus.req_vld  = 4'b1111;
      bus.req_mask = 4'b1010;
      bus.out_rdy  = 1'b1;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL mask_first_gnt got %b want 0010", bus.req_rdy); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.out_data !== beat(tags[k], payload(tags[k]))) begin n_bad++; $display("FAIL mask_beat k=%0d got %h want %h", k, bus.out_data, beat(tags[k], payload(tags[k]))); end
         n_cmp++; if (bus.req_rdy !== rdys[k]) begin n_bad++; $display("FAIL mask_gnt k=%0d got %b want %b", k, bus.req_rdy, rdys[k]); end
         $display("mask: beat %0d tag=%0d", k, bus.out_data[DW +: 2]);
      end
      bus.req_mask = 4'b0000;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0000) begin n_bad++; $display("FAIL mask_off_gnt got %b want 0000", bus.req_rdy); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL mask_drain c=%0d got %b want 0", c, bus.out_vld); end
      end
      bus.req_mask = 4'b1111;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0100) begin n_bad++; $display("FAIL mask_ptr_kept got %b want 0100", bus.req_rdy); end
      @(negedge clk); #1;
      n_cmp++; if (bus.out_data !== beat(2, payload(2))) begin n_bad++; $display("FAIL mask_resume got %h want %h", bus.out_data, beat(2, payload(2))); end
      $display("mask: resumed tag=%0d", bus.out_data[DW +: 2]);
   endtask

   task automatic test_wrap_skip();
      reset_dut();
      @(negedge clk);
      rst         = 1'b0;
      bus.req_vld = 4'b0100;
      bus.out_rdy = 1'b1;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0100) begin n_bad++; $display("FAIL wrap_setup_gnt got %b want 0100", bus.req_rdy); end
      @(negedge clk); #1;
      n_cmp++; if (bus.out_data !== beat(2, payload(2))) begin n_bad++; $display("FAIL wrap_setup_beat got %h want %h", bus.out_data, beat(2, payload(2))); end
      bus.req_vld = 4'b0010;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL wrap_gnt1 got %b want 0010", bus.req_rdy); end
      @(negedge clk); #1;
      n_cmp++; if (bus.out_data !== beat(1, payload(1))) begin n_bad++; $display("FAIL wrap_beat1 got %h want %h", bus.out_data, beat(1, payload(1))); end
      bus.req_vld = 4'b0101;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0100) begin n_bad++; $display("FAIL wrap_skip_gnt got %b want 0100", bus.req_rdy); end
      @(negedge clk); #1;
      n_cmp++; if (bus.out_data !== beat(2, payload(2))) begin n_bad++; $display("FAIL wrap_skip_beat got %h want %h", bus.out_data, beat(2, payload(2))); end
      n_cmp++; if (bus.req_rdy !== 4'b0001) begin n_bad++; $display("FAIL wrap_to_zero got %b want 0001", bus.req_rdy); end
      $display("wrap: last tag=%0d", bus.out_data[DW +: 2]);
   endtask

   task automatic test_midstall_reset();
      reset_dut();
      @(negedge clk);
      rst         = 1'b0;
      bus.req_vld = 4'b0010;
      bus.out_rdy = 1'b0;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL msr_gnt got %b want 0010", bus.req_rdy); end
      @(negedge clk);
      bus.req_vld = 4'b0000;
      #1;
      n_cmp++; if (bus.out_data !== beat(1, payload(1))) begin n_bad++; $display("FAIL msr_beat got %h want %h", bus.out_data, beat(1, payload(1))); end
      @(negedge clk);
      @(negedge clk); #1;
      n_cmp++; if (bus.busy_cnt !== 16'd2) begin n_bad++; $display("FAIL msr_busy got %0d want 2", bus.busy_cnt); end
      rst = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL msr_vld got %b want 0", bus.out_vld); end
      n_cmp++; if (bus.busy_cnt !== 16'd0) begin n_bad++; $display("FAIL msr_busy_clr got %0d want 0", bus.busy_cnt); end
      n_cmp++; if (bus.out_data !== 66'd0) begin n_bad++; $display("FAIL msr_data_clr got %h want 0", bus.out_data); end
      rst         = 1'b0;
      bus.out_rdy = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL msr_no_stale c=%0d got %b want 0", c, bus.out_vld); end
      end
      bus.req_vld = 4'b0110;
      #1;
      n_cmp++; if (bus.req_rdy !== 4'b0010) begin n_bad++; $display("FAIL msr_ptr_clr got %b want 0010", bus.req_rdy); end
      @(negedge clk); #1;
      n_cmp++; if (bus.out_data !== beat(1, payload(1))) begin n_bad++; $display("FAIL msr_after_beat got %h want %h", bus.out_data, beat(1, payload(1))); end
      $display("msr: post-reset tag=%0d", bus.out_data[DW +: 2]);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_round_robin();
      test_backpressure();
      test_mask();
      test_wrap_skip();
      test_midstall_reset();
      reset_dut();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
